// File: rtl/ser2par32_zdet_pkg.sv
// Shared widths and the shift-in helper for the serial-to-parallel collector.
package ser2par32_zdet_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = 5'd31;

  // Shift one bit into the word in the configured arrival order.
  function automatic logic [WORD_W-1:0] shift_in(input logic [WORD_W-1:0] sr,
                                                 input logic              b,
                                                 input bit                lsb_first);
    if (lsb_first) return {b, sr[WORD_W-1:1]};
    else           return {sr[WORD_W-2:0], b};
  endfunction

endpackage

// File: rtl/ser2par32_zdet_nor32_1b.sv
// 32-to-1 NOR reduction: z is 1 iff every bit of a is 0.
module nor32_1b (
  input  logic [31:0] a,
  output logic        z
);

  assign z = ~|a;

endmodule

// File: rtl/ser2par32_zdet.sv
// Bit-serial to 32-bit parallel collector with a registered output word and
// a zero flag, both under valid/ready handshakes.
module ser2par32_zdet
  import ser2par32_zdet_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_zero
);

  logic [WORD_W-1:0] sr_q, sr_d, sr_shift;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              accept, complete;

  // Only the 32nd bit can stall; earlier bits never need the output register.
  assign in_ready = (cnt_q != CNT_LAST) || !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign complete = accept && (cnt_q == CNT_LAST);
  assign sr_shift = shift_in(sr_q, in_bit, LSB_FIRST);

  always_comb begin
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    if (flush) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (accept) begin
      sr_d  = sr_shift;
      cnt_d = cnt_q + 5'd1;
    end

    // A completion wins over a consume in the same cycle so no gap appears.
    if (complete) begin
      out_data_d  = sr_shift;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q        <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

  nor32_1b u_zdet (
    .a (out_data_q),
    .z (out_zero)
  );

endmodule
